// File: rtl/proj_to_affine_if.sv
// Start/operand/result bundle for proj_to_affine: projective (X:Y:Z) in, affine (x, y) out.
// The master drives the job, the slave (the converter) returns results.
interface proj_to_affine_if #(
  parameter int W = 255
);
  logic         i_start;
  logic [W-1:0] i_x;
  logic [W-1:0] i_y;
  logic [W-1:0] i_z;
  logic         o_ready;
  logic [W-1:0] o_x;
  logic [W-1:0] o_y;
  logic         o_error;
  logic         o_finished;

  modport master (
    output i_start, i_x, i_y, i_z,
    input  o_ready, o_x, o_y, o_error, o_finished
  );

  modport slave (
    input  i_start, i_x, i_y, i_z,
    output o_ready, o_x, o_y, o_error, o_finished
  );
endinterface

// File: rtl/proj_to_affine.sv
// Projective (X:Y:Z) to affine (X/Z, Y/Z) mod p = 2^255-19: binary extended Euclid inversion,
// then two bit-serial modular multipliers. Optional macro Z1_BYPASS_EN short-cuts Z==1.
module proj_to_affine #(
  parameter int           W = 255,
  parameter logic [W-1:0] P = 255'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFED
) (
  input  logic            i_clk,
  input  logic            i_rst,
  proj_to_affine_if.slave bus
);

  localparam logic [W:0]   P_EXT = {1'b0, P};
  localparam logic [W-1:0] ONE   = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_REDUCE,
    S_INV,
    S_MUL,
    S_DONE
  } state_t;

  state_t       state;
  logic [W-1:0] x_r, y_r;
  logic [W-1:0] u, v, x1, x2;
  logic [W-1:0] zinv;
  logic [W-1:0] acc_x, acc_y;
  logic [7:0]   cnt;

  logic [W-1:0] z_red;
  logic [W-1:0] acc_x_nxt, acc_y_nxt;

  function automatic logic [W-1:0] cond_sub(input logic [W-1:0] a);
    return (a >= P) ? a - P : a;
  endfunction

  // a/2 mod P; adding P to an odd value needs the extra carry bit before the shift.
  function automatic logic [W-1:0] half_mod(input logic [W-1:0] a);
    logic [W:0] s;
    s = a[0] ? {1'b0, a} + P_EXT : {1'b0, a};
    return s[W:1];
  endfunction

  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} - {1'b0, b};
    if (s[W]) s = s + P_EXT;
    return s[W-1:0];
  endfunction

  // One MSB-first step: acc = 2*acc (+ op if bit), kept below P after each addition.
  function automatic logic [W-1:0] mul_step(input logic [W-1:0] acc, input logic [W-1:0] op,
                                            input logic b);
    logic [W:0] d;
    d = {acc, 1'b0};
    if (d >= P_EXT) d = d - P_EXT;
    if (b) d = d + {1'b0, op};
    if (d >= P_EXT) d = d - P_EXT;
    return d[W-1:0];
  endfunction

  // u holds the raw latched Z while in S_REDUCE.
  assign z_red     = cond_sub(u);
  assign acc_x_nxt = mul_step(acc_x, x_r, zinv[W-1]);
  assign acc_y_nxt = mul_step(acc_y, y_r, zinv[W-1]);

  always_ff @(posedge i_clk) begin
    // NOTE: only control state and outputs are reset; the datapath registers are always
    // loaded before they are read, so resetting them would only add reset fan-out.
    if (i_rst) begin
      state          <= S_IDLE;
      bus.o_ready    <= 1'b1;
      bus.o_finished <= 1'b0;
      bus.o_error    <= 1'b0;
      bus.o_x        <= '0;
      bus.o_y        <= ONE;
    end else begin
      bus.o_finished <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            x_r         <= bus.i_x;
            y_r         <= bus.i_y;
            u           <= bus.i_z;
            bus.o_ready <= 1'b0;
            state       <= S_REDUCE;
          end
        end

        S_REDUCE: begin
          x_r <= cond_sub(x_r);
          y_r <= cond_sub(y_r);
          if (z_red == '0) begin
            bus.o_x        <= '0;
            bus.o_y        <= ONE;
            bus.o_error    <= 1'b1;
            bus.o_finished <= 1'b1;
            state          <= S_DONE;
          end
`ifdef Z1_BYPASS_EN
          else if (z_red == ONE) begin
            bus.o_x        <= cond_sub(x_r);
            bus.o_y        <= cond_sub(y_r);
            bus.o_error    <= 1'b0;
            bus.o_finished <= 1'b1;
            state          <= S_DONE;
          end
`endif
          else begin
            u     <= z_red;
            v     <= P;
            x1    <= ONE;
            x2    <= '0;
            state <= S_INV;
          end
        end

        S_INV: begin
          if (u == ONE || v == ONE) begin
            zinv  <= (u == ONE) ? x1 : x2;
            acc_x <= '0;
            acc_y <= '0;
            cnt   <= 8'(W - 1);
            state <= S_MUL;
          end else if (!u[0]) begin
            u  <= u >> 1;
            x1 <= half_mod(x1);
          end else if (!v[0]) begin
            v  <= v >> 1;
            x2 <= half_mod(x2);
          end else if (u >= v) begin
            u  <= u - v;
            x1 <= sub_mod(x1, x2);
          end else begin
            v  <= v - u;
            x2 <= sub_mod(x2, x1);
          end
        end

        // zinv shifts left so its current bit is always the MSB.
        S_MUL: begin
          acc_x <= acc_x_nxt;
          acc_y <= acc_y_nxt;
          zinv  <= zinv << 1;
          if (cnt == 8'd0) begin
            bus.o_x        <= acc_x_nxt;
            bus.o_y        <= acc_y_nxt;
            bus.o_error    <= 1'b0;
            bus.o_finished <= 1'b1;
            state          <= S_DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        S_DONE: begin
          bus.o_ready <= 1'b1;
          state       <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proj_to_affine.sv
// Bench for proj_to_affine: a plain modular-arithmetic model (Fermat inverse, wide multiply)
// feeds an expectation queue checked on every o_finished pulse, plus hand-computed vectors.
module tb_proj_to_affine;

  localparam int           W = 255;
  localparam logic [W-1:0] P = 255'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFED;
`ifdef Z1_BYPASS_EN
  localparam int LAT_Z1 = 3;
`else
  localparam int LAT_Z1 = 259;
`endif
  localparam int LAT_MAX = 1278;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         err;
  } res_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  proj_to_affine_if #(.W(W)) bus ();

  proj_to_affine #(.W(W), .P(P)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  int   total  = 0;
  int   bad    = 0;
  int   pulses = 0;
  res_t exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- model: plain modular arithmetic ----------------
  function automatic logic [W-1:0] mmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] t;
    t = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    t = t % {{W{1'b0}}, P};
    return t[W-1:0];
  endfunction

  // z^(P-2) mod P
  function automatic logic [W-1:0] minv(input logic [W-1:0] z);
    logic [W-1:0] e;
    logic [W-1:0] r;
    e = P - W'(2);
    r = W'(1);
    for (int i = W - 1; i >= 0; i--) begin
      r = mmul(r, r);
      if (e[i]) r = mmul(r, z);
    end
    return r;
  endfunction

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [W-1:0] z);
    res_t         r;
    logic [W-1:0] zi;
    if (z % P == '0) begin
      r.x   = '0;
      r.y   = W'(1);
      r.err = 1'b1;
    end else begin
      zi    = minv(z % P);
      r.x   = mmul(x % P, zi);
      r.y   = mmul(y % P, zi);
      r.err = 1'b0;
    end
    return r;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge i_clk) begin
    if (!i_rst && bus.o_finished) begin
      res_t e;
      pulses++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_finish: got pulse want none");
      end else begin
        e = exp_q.pop_front();
        check("cmp_x", bus.o_x, e.x);
        check("cmp_y", bus.o_y, e.y);
        check_bit("cmp_err", bus.o_error, e.err);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_job(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    @(negedge i_clk);
    check_bit("ready_before_start", bus.o_ready, 1'b1);
    bus.i_x     = x;
    bus.i_y     = y;
    bus.i_z     = z;
    bus.i_start = 1'b1;
    exp_q.push_back(model(x, y, z));
    @(posedge i_clk);
    #1 bus.i_start = 1'b0;
  endtask

  // Returns the latency counted from the cycle in which i_start is presented (that cycle = 1).
  task automatic wait_finish(input string tag, output int lat);
    int k;
    k = 1;
    while (!bus.o_finished && k < 1400) begin
      @(posedge i_clk);
      #1 k++;
    end
    check_bit({tag, "_finish_in_budget"}, bus.o_finished, 1'b1);
    lat = k + 1;
  endtask

  task automatic do_job(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] z, input logic [W-1:0] ex, input logic [W-1:0] ey,
                        input logic eerr, input int lat_lo, input int lat_hi);
    res_t m;
    int   p0;
    int   lat;
    m = model(x, y, z);
    check({tag, "_model_x"}, m.x, ex);
    check({tag, "_model_y"}, m.y, ey);
    check_bit({tag, "_model_err"}, m.err, eerr);
    p0 = pulses;
    start_job(x, y, z);
    wait_finish(tag, lat);
    check_int({tag, "_latency"}, lat, lat_lo, lat_hi);
    check_bit({tag, "_ready_low_at_finish"}, bus.o_ready, 1'b0);
    @(posedge i_clk);
    #1;
    check_bit({tag, "_ready_after"}, bus.o_ready, 1'b1);
    check_bit({tag, "_finish_one_cycle"}, bus.o_finished, 1'b0);
    repeat (3) @(posedge i_clk);
    #1;
    check_int({tag, "_pulse_count"}, pulses - p0, 1, 1);
    check({tag, "_hold_x"}, bus.o_x, ex);
    check({tag, "_hold_y"}, bus.o_y, ey);
    check_bit({tag, "_hold_err"}, bus.o_error, eerr);
  endtask

  initial begin
    int           p0;
    int           lat;
    res_t         first;
    logic [W-1:0] bx, by, bz;

    bus.i_start = 1'b0;
    bus.i_x     = '0;
    bus.i_y     = '0;
    bus.i_z     = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_x", bus.o_x, '0);
    check("reset_y", bus.o_y, W'(1));
    check_bit("reset_err", bus.o_error, 1'b0);
    check_bit("reset_finished", bus.o_finished, 1'b0);
    check_bit("reset_ready", bus.o_ready, 1'b1);
    @(negedge i_clk);
    i_rst = 1'b0;

    do_job("z1", W'(5), W'(7), W'(1), W'(5), W'(7), 1'b0, LAT_Z1, LAT_Z1);
    do_job("z2", W'(2), W'(4), W'(2), W'(1), W'(2), 1'b0, 4, LAT_MAX);
    do_job("zm1", W'(3), W'(1), P - W'(1), P - W'(3), P - W'(1), 1'b0, 4, LAT_MAX);
    do_job("unred", P + W'(1), P + W'(2), P + W'(1), W'(1), W'(2), 1'b0, LAT_Z1, LAT_Z1);
    do_job("z0", W'(9), W'(11), '0, '0, W'(1), 1'b1, 3, 3);
    do_job("zp", W'(9), W'(11), P, '0, W'(1), 1'b1, 3, 3);

    // Busy: a second start 10 cycles into the inversion must be ignored.
    bx = 255'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321_1111_2222_3333_4444_5555_6666_7777_8888;
    by = 255'h0BAD_CAFE_DEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_AAAA_5555_CCCC_3333;
    bz = 255'h3141_5926_5358_9793_2384_6264_3383_2795_0288_4197_1693_9937_5105_8209_7494_4592;
    first = model(bx, by, bz);
    p0 = pulses;
    start_job(bx, by, bz);
    repeat (10) @(posedge i_clk);
    @(negedge i_clk);
    check_bit("busy_ready_low", bus.o_ready, 1'b0);
    bus.i_x     = W'(77);
    bus.i_y     = W'(88);
    bus.i_z     = W'(3);
    bus.i_start = 1'b1;
    @(posedge i_clk);
    #1 bus.i_start = 1'b0;
    wait_finish("busy", lat);
    check_int("busy_latency", lat, 4, LAT_MAX);
    repeat (4) @(posedge i_clk);
    #1;
    check_int("busy_pulse_count", pulses - p0, 1, 1);
    check("busy_x", bus.o_x, first.x);
    check("busy_y", bus.o_y, first.y);

    // Reset 100 cycles into a job aborts it without a pulse.
    p0 = pulses;
    start_job(by, bx, bz ^ W'(255'h5A5A));
    repeat (99) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    exp_q.delete();
    check("abort_x", bus.o_x, '0);
    check("abort_y", bus.o_y, W'(1));
    check_bit("abort_err", bus.o_error, 1'b0);
    check_bit("abort_ready", bus.o_ready, 1'b1);
    check_bit("abort_finished", bus.o_finished, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (1400) @(posedge i_clk);
    #1;
    check_int("abort_no_pulse", pulses - p0, 0, 0);

    do_job("after_rst", W'(2), W'(4), W'(2), W'(1), W'(2), 1'b0, 4, LAT_MAX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
